seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 137 +++++++++++++
 tb/tb_seq_multiplier.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier retiring STEP multiplier bits per cycle.
// Signed operands are handled as magnitudes with a final conditional negate.
module seq_multiplier #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iStart,
    input  logic               iSigned,
    input  logic               iClear,
    input  logic [WIDTH-1:0]   iData_A,
    input  logic [WIDTH-1:0]   iData_B,
    output logic               oReady,
    output logic               oDone,
    output logic [2*WIDTH-1:0] oResult
);

    localparam int ITER  = WIDTH / STEP;
    localparam int ACC_W = 2 * WIDTH + STEP;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic                 start_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [ACC_W-1:0]     acc_r;
    logic [ACC_W-1:0]     acc_step_s;
    logic [WIDTH-1:0]     mag_a_r;
    logic                 neg_r;
    logic [WIDTH+STEP-1:0] partial_s;
    logic [WIDTH+STEP-1:0] sum_s;
    logic [2*WIDTH-1:0]   final_s;
    logic [2*WIDTH-1:0]   result_r;
    logic                 done_r;
    logic                 ready_r;

    // -2^(WIDTH-1) maps onto 2^(WIDTH-1), which still fits the unsigned field.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Next-state logic; clear always wins over start and completion.
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (iClear) begin
                    state_s = IDLE;
                end else if (iStart) begin
                    state_s = BUSY;
                    start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (iClear) begin
                    state_s = IDLE;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // One shift-add step: upper half gains (multiplier bits x multiplicand), then shift.
    always_comb begin
        partial_s  = {{STEP{1'b0}}, mag_a_r} * {{WIDTH{1'b0}}, acc_r[STEP-1:0]};
        sum_s      = acc_r[ACC_W-1:WIDTH] + partial_s;
        acc_step_s = {sum_s, acc_r[WIDTH-1:0]} >> STEP;
        final_s    = neg_r ? negate(acc_r[2*WIDTH-1:0]) : acc_r[2*WIDTH-1:0];
    end

    // State register with registered ready/done strobes.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    // Operand capture, iteration datapath and result hold register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {ACC_W{1'b0}};
            mag_a_r  <= {WIDTH{1'b0}};
            neg_r    <= 1'b0;
            result_r <= {(2*WIDTH){1'b0}};
        end else begin
            if (start_s) begin
                acc_r   <= {{(WIDTH+STEP){1'b0}}, magnitude(iData_B, iSigned)};
                mag_a_r <= magnitude(iData_A, iSigned);
                neg_r   <= iSigned & (iData_A[WIDTH-1] ^ iData_B[WIDTH-1]);
                cnt_r   <= CNT_LOAD;
            end else if ((state_r == BUSY) && (cnt_r != {CNT_W{1'b0}})) begin
                acc_r <= acc_step_s;
                cnt_r <= cnt_r - CNT_ONE;
            end
            if (state_s == DONE) begin
                result_r <= final_s;
            end
        end
    end

    assign oReady  = ready_r;
    assign oDone   = done_r;
    assign oResult = result_r;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed corner cases plus a random
// sweep over three parameter sets against an arithmetic reference model.
module tb_seq_multiplier;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iStart;
    logic        iSigned;
    logic        iClear;
    logic [15:0] a_s;
    logic [15:0] b_s;

    logic        rdy0, rdy1, rdy2;
    logic        don0, don1, don2;
    logic [31:0] r0, r1;
    logic [15:0] r2;

    logic        rdy_a [3];
    logic        don_a [3];
    logic [31:0] res_a [3];

    int n_cmp = 0;
    int n_err = 0;
    int w_tab [3] = '{16, 16, 8};
    int n_tab [3] = '{16, 4, 4};

    assign rdy_a[0] = rdy0;
    assign rdy_a[1] = rdy1;
    assign rdy_a[2] = rdy2;
    assign don_a[0] = don0;
    assign don_a[1] = don1;
    assign don_a[2] = don2;
    assign res_a[0] = r0;
    assign res_a[1] = r1;
    assign res_a[2] = {16'd0, r2};

    always #5 Clock = ~Clock;

    seq_multiplier #(.WIDTH(16), .STEP(1)) u_m16s1 (
        .Clock(Clock), .Reset(Reset), .iStart(iStart), .iSigned(iSigned), .iClear(iClear),
        .iData_A(a_s), .iData_B(b_s), .oReady(rdy0), .oDone(don0), .oResult(r0));

    seq_multiplier #(.WIDTH(16), .STEP(4)) u_m16s4 (
        .Clock(Clock), .Reset(Reset), .iStart(iStart), .iSigned(iSigned), .iClear(iClear),
        .iData_A(a_s), .iData_B(b_s), .oReady(rdy1), .oDone(don1), .oResult(r1));

    seq_multiplier #(.WIDTH(8), .STEP(2)) u_m8s2 (
        .Clock(Clock), .Reset(Reset), .iStart(iStart), .iSigned(iSigned), .iClear(iClear),
        .iData_A(a_s[7:0]), .iData_B(b_s[7:0]), .oReady(rdy2), .oDone(don2), .oResult(r2));

    // Exact product modulo 2^(2w), computed with plain integer arithmetic.
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input bit sgn, input int w);
        longint va, vb, m;
        m  = (longint'(1) << w) - 1;
        va = longint'(a) & m;
        vb = longint'(b) & m;
        if (sgn && va[w-1]) va = va - (longint'(1) << w);
        if (sgn && vb[w-1]) vb = vb - (longint'(1) << w);
        return 32'((va * vb) & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic wait_done(input int which, output int n);
        n = 0;
        do begin
            @(posedge Clock); #1;
            n++;
        end while (!don_a[which] && n < 60);
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic sgn);
        a_s = a; b_s = b; iSigned = sgn; iStart = 1'b1;
        @(posedge Clock); #1;
        iStart = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; iStart = 1'b0; iClear = 1'b0; iSigned = 1'b0; a_s = 16'd0; b_s = 16'd0;
        #12;
        for (int i = 0; i < 3; i++) begin
            n_cmp += 3;
            if (rdy_a[i] !== 1'b1) begin n_err++; $display("FAIL reset_ready[%0d]: got %b want 1", i, rdy_a[i]); end
            if (don_a[i] !== 1'b0) begin n_err++; $display("FAIL reset_done[%0d]: got %b want 0", i, don_a[i]); end
            if (res_a[i] !== 32'd0) begin n_err++; $display("FAIL reset_result[%0d]: got %0h want 0", i, res_a[i]); end
        end
        @(posedge Clock); #1;
        Reset = 1'b1;
        start_op(16'd1, 16'd1, 1'b0);
        n_cmp++;
        if (rdy0 !== 1'b0) begin n_err++; $display("FAIL first_start: ready got %b want 0", rdy0); end
        repeat (20) @(posedge Clock);
        #1;
    endtask

    task automatic test_basic();
        int n;
        start_op(16'd3, 16'd5, 1'b0);
        wait_done(0, n);
        n_cmp += 4;
        if (n != 17) begin n_err++; $display("FAIL basic_latency: got %0d edges want 17", n); end
        if (r0 !== 32'h0000000F) begin n_err++; $display("FAIL basic_result: got %0h want f", r0); end
        if (rdy0 !== 1'b0) begin n_err++; $display("FAIL basic_ready_in_done: got %b want 0", rdy0); end
        @(posedge Clock); #1;
        if (rdy0 !== 1'b1 || don0 !== 1'b0) begin
            n_err++; $display("FAIL basic_after_done: ready %b done %b want 1 0", rdy0, don0);
        end
    endtask

    task automatic test_products();
        logic [15:0] ta [5] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000, 16'h0000};
        logic [15:0] tb [5] = '{16'hFFFF, 16'h0002, 16'h8000, 16'h0001, 16'h1234};
        logic        ts [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] te [5] = '{32'hFFFE0001, 32'hFFFFFFFE, 32'h40000000, 32'hFFFF8000, 32'h00000000};
        int n;
        for (int k = 0; k < 5; k++) begin
            start_op(ta[k], tb[k], ts[k]);
            wait_done(0, n);
            n_cmp += 2;
            if (n != 17) begin n_err++; $display("FAIL product_latency[%0d]: got %0d want 17", k, n); end
            if (r0 !== te[k]) begin n_err++; $display("FAIL product[%0d]: got %0h want %0h", k, r0, te[k]); end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_ignore_start();
        int cnt;
        logic [31:0] got;
        cnt = 0; got = 32'd0;
        start_op(16'd3, 16'd5, 1'b0);
        repeat (4) @(posedge Clock);
        #1;
        start_op(16'hFFFF, 16'hFFFF, 1'b0);
        a_s = 16'd0; b_s = 16'd0;
        for (int k = 0; k < 40; k++) begin
            @(posedge Clock); #1;
            if (don0) begin cnt++; got = r0; end
        end
        n_cmp += 2;
        if (cnt != 1) begin n_err++; $display("FAIL ignore_start_count: got %0d want 1", cnt); end
        if (got !== 32'h0000000F) begin n_err++; $display("FAIL ignore_start_result: got %0h want f", got); end
    endtask

    task automatic test_clear();
        int cnt;
        cnt = 0;
        start_op(16'h1234, 16'h5678, 1'b0);
        repeat (4) @(posedge Clock);
        #1;
        iClear = 1'b1;
        @(posedge Clock); #1;
        iClear = 1'b0;
        n_cmp += 1;
        if (rdy0 !== 1'b1 || don0 !== 1'b0) begin
            n_err++; $display("FAIL clear_to_idle: ready %b done %b want 1 0", rdy0, don0);
        end
        for (int k = 0; k < 30; k++) begin
            @(posedge Clock); #1;
            if (don0) cnt++;
        end
        n_cmp += 2;
        if (cnt != 0) begin n_err++; $display("FAIL clear_no_done: got %0d pulses want 0", cnt); end
        if (r0 !== 32'h0000000F) begin n_err++; $display("FAIL clear_result_held: got %0h want f", r0); end
        iClear = 1'b1; iStart = 1'b1;
        @(posedge Clock); #1;
        iClear = 1'b0; iStart = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rdy_a[i] !== 1'b1) begin n_err++; $display("FAIL clear_priority[%0d]: ready %b want 1", i, rdy_a[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        cnt = 0;
        start_op(16'hFFFF, 16'hFFFF, 1'b0);
        repeat (6) @(posedge Clock);
        #2;
        Reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rdy_a[i] !== 1'b1 || don_a[i] !== 1'b0 || res_a[i] !== 32'd0) begin
                n_err++; $display("FAIL reset_mid[%0d]: ready %b done %b result %0h want 1 0 0",
                                  i, rdy_a[i], don_a[i], res_a[i]);
            end
        end
        @(posedge Clock); #1;
        Reset = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge Clock); #1;
            if (don0 || don1 || don2) cnt++;
        end
        n_cmp++;
        if (cnt != 0) begin n_err++; $display("FAIL reset_mid_no_done: got %0d pulses want 0", cnt); end
    endtask

    task automatic test_params();
        int n;
        start_op(16'h1234, 16'h5678, 1'b0);
        wait_done(1, n);
        n_cmp += 2;
        if (n != 5) begin n_err++; $display("FAIL step4_latency: got %0d want 5", n); end
        if (r1 !== 32'h06260060) begin n_err++; $display("FAIL step4_result: got %0h want 6260060", r1); end
        repeat (20) @(posedge Clock);
        #1;
        start_op(16'h0080, 16'h007F, 1'b1);
        wait_done(2, n);
        n_cmp += 2;
        if (n != 5) begin n_err++; $display("FAIL w8_latency: got %0d want 5", n); end
        if (r2 !== 16'hC080) begin n_err++; $display("FAIL w8_signed_result: got %0h want c080", r2); end
        repeat (20) @(posedge Clock);
        #1;
    endtask

    task automatic test_random();
        int          m_cnt  [3];
        logic [31:0] m_pend [3];
        logic [31:0] m_res  [3];
        bit          m_done [3];
        int          dut_dones [3];
        int          mdl_dones [3];
        Reset = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_pend[i] = 32'd0; m_res[i] = 32'd0; m_done[i] = 1'b0;
            dut_dones[i] = 0; mdl_dones[i] = 0;
        end
        for (int c = 0; c < 40000; c++) begin
            iStart  = ($urandom_range(0, 7) != 0);
            iClear  = ($urandom_range(0, 99) == 0);
            iSigned = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: a_s = 16'h8000;
                1: a_s = 16'hFFFF;
                2: a_s = 16'h0000;
                3: a_s = 16'h0080;
                default: a_s = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: b_s = 16'h8000;
                1: b_s = 16'hFFFF;
                2: b_s = 16'h0000;
                3: b_s = 16'h007F;
                default: b_s = 16'($urandom);
            endcase
            @(posedge Clock);
            // Model: an accepted op occupies N+2 edges; the result appears on the (N+1)th.
            for (int i = 0; i < 3; i++) begin
                if (m_cnt[i] == 0) begin
                    m_done[i] = 1'b0;
                    if (iStart && !iClear) begin
                        m_cnt[i]  = n_tab[i] + 2;
                        m_pend[i] = ref_mul(a_s, b_s, iSigned, w_tab[i]);
                    end
                end else if (iClear) begin
                    m_cnt[i]  = 0;
                    m_done[i] = 1'b0;
                end else begin
                    m_cnt[i]--;
                    m_done[i] = (m_cnt[i] == 1);
                    if (m_done[i]) m_res[i] = m_pend[i];
                end
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                n_cmp += 3;
                if (rdy_a[i] !== (m_cnt[i] == 0)) begin
                    n_err++; $display("FAIL rand_ready[%0d] cyc %0d: got %b want %b", i, c, rdy_a[i], m_cnt[i] == 0);
                end
                if (don_a[i] !== m_done[i]) begin
                    n_err++; $display("FAIL rand_done[%0d] cyc %0d: got %b want %b", i, c, don_a[i], m_done[i]);
                end
                if (res_a[i] !== m_res[i]) begin
                    n_err++; $display("FAIL rand_result[%0d] cyc %0d: got %0h want %0h", i, c, res_a[i], m_res[i]);
                end
                if (don_a[i]) dut_dones[i]++;
                if (m_done[i]) mdl_dones[i]++;
            end
        end
        iStart = 1'b0; iClear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (dut_dones[i] != mdl_dones[i]) begin
                n_err++; $display("FAIL rand_done_count[%0d]: got %0d want %0d", i, dut_dones[i], mdl_dones[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_products();
        test_ignore_start();
        test_clear();
        test_reset_mid();
        test_params();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
